// File: rtl/pixel_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo_ctrl
//  Description : Valid/ready FIFO controller wrapped around a two-port pixel
//                RAM that writes every clock (no write enable) and reads
//                combinationally. The write address is parked on a free
//                "scratch" slot whenever no push occurs, so usable capacity
//                is 2**WIDTH-1 entries.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                flush             - synchronous clear of FIFO contents
//                in_valid/in_data/in_ready    - upstream (producer) side
//                out_valid/out_data/out_ready - downstream (consumer) side
//                ram_write_addr/ram_din       - RAM write port
//                ram_read_addr/ram_dout       - RAM read port
//                count, almost_full, overflow - status
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo_ctrl #(
    parameter int WIDTH       = 4,
    parameter int LENGTH      = 8,
    parameter int AFULL_LEVEL = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [LENGTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [LENGTH-1:0] out_data,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  ram_write_addr,
    output logic [LENGTH-1:0] ram_din,
    output logic [WIDTH-1:0]  ram_read_addr,
    input  logic [LENGTH-1:0] ram_dout,
    output logic [WIDTH-1:0]  count,
    output logic              almost_full,
    output logic              overflow
);

    // All-ones count is the capacity limit: one slot always stays free.
    localparam logic [WIDTH-1:0] c_full_count  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_afull_level = WIDTH'(AFULL_LEVEL);

    logic [WIDTH-1:0] r_wr_ptr;
    logic [WIDTH-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_count;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);

    // in_ready deliberately ignores out_ready: no pass-through when full.
    assign in_ready  = !w_full && !flush;
    assign out_valid = !w_empty && !flush;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // The RAM writes slot r_wr_ptr every clock; without a push that slot is
    // the scratch slot, which never holds live data.
    assign ram_write_addr = r_wr_ptr;
    assign ram_din        = in_data;
    assign ram_read_addr  = r_rd_ptr;
    assign out_data       = ram_dout;

    assign count       = r_count;
    assign almost_full = (r_count >= c_afull_level);
    assign overflow    = r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Pointers wrap naturally at WIDTH bits.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Sticky: an attempted write into a full FIFO is an error.
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
